// File: rtl/timer_multi.sv
// timer_multi: memory-mapped multi-channel compare timer.
// One free-running cycle counter is shared by NUM_CH compare channels.
// Each channel is one-shot (PERIOD == 0) or auto-reloading (PERIOD != 0).
// Define TIMER_PRESCALE_EN to add a PRESCALE register at offset 0x0C that
// slows the counter; without it, 0x0C is a read-as-zero hole.
module timer_multi #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic [31:0]       wr_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              address_hit,
  output logic [31:0]       read_data,
  output logic              interrupt,
  output logic [NUM_CH-1:0] pending
);

  localparam int          NUM_REGS  = 4 + 2 * NUM_CH;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Architectural state
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cmp [NUM_CH];
  logic [CNT_W-1:0]  per [NUM_CH];
  logic [NUM_CH-1:0] enable;

  // Decode helpers
  logic [29:0]       word_off;
  logic              wr_en;
  logic              cycle_wr;
  logic              ack_wr;
  logic              enable_wr;
  logic [NUM_CH-1:0] cmp_wr;
  logic [NUM_CH-1:0] per_wr;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] fire;
  logic              tick;
  logic              fresh;
  logic              unused_bits;

  // Zero-extend a counter-width value onto the 32-bit load path.
  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  // Zero-extend a per-channel mask onto the 32-bit load path.
  function automatic logic [31:0] zext_mask(input logic [NUM_CH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_CH-1:0] = v;
    return r;
  endfunction

  // Byte-address bits [1:0] are ignored; upper store-data bits are unused
  // when CNT_W < 32.
  assign unused_bits = ^{address[1:0], wr_data};

  // Word offset into the register window; out-of-range (including below
  // BASE_ADDR, which wraps to a large value) is a miss.
  assign word_off    = address[31:2] - BASE_WORD;
  assign address_hit = (word_off < 30'(NUM_REGS));

  assign wr_en     = MemWrite & address_hit;
  assign cycle_wr  = wr_en && (word_off == 30'd0);
  assign ack_wr    = wr_en && (word_off == 30'd1);
  assign enable_wr = wr_en && (word_off == 30'd2);

`ifdef TIMER_PRESCALE_EN
  logic             presc_wr;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] div;

  assign presc_wr = wr_en && (word_off == 30'd3);
  assign tick     = (div == presc);

  // Prescale divider; fresh marks the first cycle a counter value is held
  // so that slow counts fire each match only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      div   <= '0;
      fresh <= 1'b1;
    end else begin
      if (presc_wr)
        presc <= wr_data[CNT_W-1:0];
      if (cycle_wr || presc_wr || tick)
        div <= '0;
      else
        div <= div + CNT_ONE;
      fresh <= cycle_wr || tick;
    end
  end
`else
  assign tick  = 1'b1;
  assign fresh = 1'b1;
`endif

  // Per-channel write strobes and match/fire evaluation on registered values.
  always_comb begin
    cmp_wr = '0;
    per_wr = '0;
    match  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_wr[i] = wr_en && (word_off == 30'(4 + 2 * i));
      per_wr[i] = wr_en && (word_off == 30'(5 + 2 * i));
      match[i]  = enable[i] && (cnt == cmp[i]);
    end
    fire = match & {NUM_CH{fresh}};
  end

  // Free-running counter; a CYCLE write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cycle_wr)
      cnt <= wr_data[CNT_W-1:0];
    else if (tick)
      cnt <= cnt + CNT_ONE;
  end

  // Channel registers: compare/period, enable, pending and interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cmp[i] <= '0;
        per[i] <= '0;
      end
      enable    <= '0;
      pending   <= '0;
      interrupt <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // A software write to COMPARE overrides the auto-reload.
        if (cmp_wr[i])
          cmp[i] <= wr_data[CNT_W-1:0];
        else if (fire[i] && (per[i] != '0))
          cmp[i] <= cmp[i] + per[i];
        if (per_wr[i])
          per[i] <= wr_data[CNT_W-1:0];
      end
      if (enable_wr)
        enable <= wr_data[NUM_CH-1:0];
      // A new match beats a simultaneous ACK of the same channel.
      pending   <= (ack_wr ? (pending & ~wr_data[NUM_CH-1:0]) : pending) | fire;
      interrupt <= |(pending & enable);
    end
  end

  // Register read mux onto the load path; zero when not a hitting load.
  always_comb begin
    read_data = '0;
    if (MemRead && address_hit) begin
      case (word_off)
        30'd0:   read_data = zext_cnt(cnt);
        30'd1:   read_data = zext_mask(pending);
        30'd2:   read_data = zext_mask(enable);
`ifdef TIMER_PRESCALE_EN
        30'd3:   read_data = zext_cnt(presc);
`endif
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (word_off == 30'(4 + 2 * i))
              read_data = zext_cnt(cmp[i]);
            if (word_off == 30'(5 + 2 * i))
              read_data = zext_cnt(per[i]);
          end
        end
      endcase
    end
  end

endmodule
